// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encodings and counter sizing shared by the serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/fulladd.sv
// fulladd: single-bit full adder cell.
module fulladd (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ z;
    assign cout = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder over one fulladd cell.
// SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c, last;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    fulladd u_fa (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .z    (carry_q),
        .sum  (fa_s),
        .cout (fa_c)
    );

    assign last = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                carry_d = cin;
                s_d     = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                s_d     = (s_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    sum_d   = s_d;
                    cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is still the carry into the MSB here
                    ovf_d   = carry_q ^ fa_c;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, cin8 = 1'b0, start1 = 1'b0, cin1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy8, done8, cout8, busy1, done1, cout1;
    logic [7:0] sum8;
    logic [0:0] sum1;
    logic       ovf8, ovf1;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf8 = 1'b0;
    assign ovf1 = 1'b0;
`endif

    typedef struct {
        logic [7:0] a, b;
        logic       ci;
        logic [7:0] s;
        logic       co, ov;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + 9'(c);
    endfunction

    function automatic logic model_ovf(input logic [7:0] x, input logic [7:0] y, input logic [7:0] s);
        return (x[7] == y[7]) && (s[7] != x[7]);
    endfunction

    // lat is the edge, counted from the accept edge, at which done is sampled high
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       output logic [7:0] s, output logic co, output logic ov, output int lat);
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        chk("busy_after_accept8", busy8, 1);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done8) begin lat = n + 1; break; end
        end
        s = sum8; co = cout8; ov = ovf8;
        @(posedge clk);
        #1;
        chk("done_one_cycle8", {busy8, done8}, 0);
    endtask

    task automatic op1(input logic av, input logic bv, input logic ci,
                       output logic [1:0] r, output int lat);
        @(negedge clk);
        a1 = av; b1 = bv; cin1 = ci; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (done1) begin lat = n + 1; break; end
        end
        r = {cout1, sum1[0]};
        @(posedge clk);
        #1;
        chk("done_one_cycle1", {busy1, done1}, 0);
    endtask

    initial begin
        vec_t       tv[6];
        logic [1:0] exp1[8];
        logic [7:0] s, ra, rb;
        logic       co, ov, rc;
        logic [1:0] r1;
        logic [8:0] m;
        int         lat;
        int         dt[$];

        tv[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tv[3] = '{8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 1'b1};
        tv[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tv[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        exp1  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state8", {busy8, done8, sum8, cout8, ovf8}, 0);
        chk("reset_state1", {busy1, done1, sum1, cout1, ovf1}, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[i]) begin
            op8(tv[i].a, tv[i].b, tv[i].ci, s, co, ov, lat);
            chk($sformatf("vec%0d_sum", i), s, tv[i].s);
            chk($sformatf("vec%0d_cout", i), co, tv[i].co);
            chk($sformatf("vec%0d_latency", i), lat, 9);
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("vec%0d_ovf", i), ov, tv[i].ov);
`endif
        end

        for (int i = 0; i < 8; i++) begin
            op1(i[2], i[1], i[0], r1, lat);
            chk($sformatf("w1_case%0d", i), r1, exp1[i]);
            chk($sformatf("w1_latency%0d", i), lat, 2);
        end

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            m = model(ra, rb, rc);
            op8(ra, rb, rc, s, co, ov, lat);
            chk($sformatf("rand%0d_result", i), {co, s}, m);
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("rand%0d_ovf", i), ov, model_ovf(ra, rb, m[7:0]));
`endif
        end

        // start held high: accepts only from IDLE, so one result per WIDTH+2 cycles
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        for (int t = 0; t < 32; t++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                dt.push_back(t);
                chk("b2b_sum", sum8, 8'h46);
            end
        end
        start8 = 1'b0;
        chk("b2b_pulses", dt.size(), 3);
        for (int k = 1; k < dt.size(); k++) chk("b2b_period", dt[k] - dt[k-1], 10);
        for (int n = 0; n < 20 && busy8; n++) @(posedge clk);
        #1;
        chk("b2b_idle", busy8, 0);

        // start kept high with changing operands during a run is ignored
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done8) begin start8 = 1'b0; lat = n + 1; break; end
            a8 = 8'($urandom); b8 = 8'($urandom);
        end
        start8 = 1'b0;
        chk("ignore_start_latency", lat, 9);
        chk("ignore_start_sum", {cout8, sum8}, 9'h003);
        repeat (2) @(posedge clk);
        #1;
        chk("ignore_start_idle", busy8, 0);

        // reset mid-run at edge 4
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrun_reset", {busy8, done8, sum8, cout8, ovf8}, 0);
        @(negedge clk);
        rst = 1'b0;
        op8(8'h10, 8'h20, 1'b0, s, co, ov, lat);
        chk("after_reset_result", {co, s}, 9'h030);
        chk("after_reset_latency", lat, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
